// File: rtl/hilo_mdu.sv
// HI/LO multiply-divide unit: a start captures the result into temp, HI/LO commit 5 (mult) or 10 (div) edges later.
// Latency 6/11 cycles; HILO_busy stalls D-stage. Define HILO_MDU_MADD_EN to enable madd/maddu/msub/msubu.
module hilo_mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  HILO_typeE,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        HILO_busy,
  output logic [31:0] HILO_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef HILO_MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  logic [31:0] hi, lo, tempHi, tempLo;
  logic [3:0]  count;
  logic        busy, start, isMul, isDiv, isAcc, signedMul, signedDiv, idle;
  logic [63:0] product, result;
  logic [31:0] absA, absB, uQuo, uRem, quo, rem;

  assign busy      = (count != 4'd0);
  assign idle      = !req && !busy;
  assign isMul     = (HILO_typeE == OP_MULT) || (HILO_typeE == OP_MULTU);
  assign isDiv     = (HILO_typeE == OP_DIV)  || (HILO_typeE == OP_DIVU);
  assign signedDiv = (HILO_typeE == OP_DIV);

`ifdef HILO_MDU_MADD_EN
  assign isAcc     = (HILO_typeE == OP_MADD) || (HILO_typeE == OP_MADDU) ||
                     (HILO_typeE == OP_MSUB) || (HILO_typeE == OP_MSUBU);
  assign signedMul = (HILO_typeE == OP_MULT) || (HILO_typeE == OP_MADD) ||
                     (HILO_typeE == OP_MSUB);
`else
  assign isAcc     = 1'b0;
  assign signedMul = (HILO_typeE == OP_MULT);
`endif

  assign start     = idle && (isMul || isDiv || isAcc);
  assign HILO_busy = start || busy;

  assign product = signedMul ? ({{32{A[31]}}, A} * {{32{B[31]}}, B})
                             : ({32'd0, A} * {32'd0, B});

  // Signed division on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign absA = (signedDiv && A[31]) ? -A : A;
  assign absB = (signedDiv && B[31]) ? -B : B;
  assign uQuo = (B == 32'd0) ? 32'd0 : absA / absB;
  assign uRem = (B == 32'd0) ? 32'd0 : absA % absB;
  assign quo  = (signedDiv && (A[31] ^ B[31])) ? -uQuo : uQuo;
  assign rem  = (signedDiv && A[31]) ? -uRem : uRem;

  always_comb begin
    result = {hi, lo};
    if (isMul) begin
      result = product;
    end else if (isDiv) begin
      if (B != 32'd0) result = {rem, quo};
    end
`ifdef HILO_MDU_MADD_EN
    else if ((HILO_typeE == OP_MADD) || (HILO_typeE == OP_MADDU)) begin
      result = {hi, lo} + product;
    end else if (isAcc) begin
      result = {hi, lo} - product;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi     <= 32'd0;
      lo     <= 32'd0;
      tempHi <= 32'd0;
      tempLo <= 32'd0;
      count  <= 4'd0;
    end else begin
      if (start) begin
        tempHi <= result[63:32];
        tempLo <= result[31:0];
        count  <= isDiv ? DIV_CYCLES : MUL_CYCLES;
      end else if (busy) begin
        count <= count - 4'd1;
        if (count == 4'd1) begin
          hi <= tempHi;
          lo <= tempLo;
        end
      end
      if (idle && (HILO_typeE == OP_MTHI)) hi <= A;
      if (idle && (HILO_typeE == OP_MTLO)) lo <= A;
    end
  end

  always_comb begin
    HILO_out = 32'd0;
    if (HILO_typeE == OP_MFHI) HILO_out = hi;
    else if (HILO_typeE == OP_MFLO) HILO_out = lo;
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Randomized bench for hilo_mdu against a 64-bit arithmetic model of HI/LO.
module tb_hilo_mdu;

  logic        clk;
  logic        reset;
  logic        req;
  logic [3:0]  typeE;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] out;

  int          nCmp;
  int          nFail;
  logic [31:0] refHi, refLo;

  hilo_mdu dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .HILO_typeE(typeE),
    .A         (a),
    .B         (b),
    .HILO_busy (busy),
    .HILO_out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] av,
                                        input logic [31:0] bv, input logic [63:0] hl);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur;
    sa = $signed(av);
    sb = $signed(bv);
    ua = {32'd0, av};
    ub = {32'd0, bv};
    model = hl;
    case (op)
      4'd1: model = sa * sb;
      4'd2: model = ua * ub;
      4'd3: if (bv != 0) begin sq = sa / sb; sr = sa % sb; model = {sr[31:0], sq[31:0]}; end
      4'd4: if (bv != 0) begin uq = ua / ub; ur = ua % ub; model = {ur[31:0], uq[31:0]}; end
      4'd9:  model = hl + sa * sb;
      4'd10: model = hl + ua * ub;
      4'd11: model = hl - sa * sb;
      4'd12: model = hl - ua * ub;
      default: model = hl;
    endcase
  endfunction

  // Presents one op for one cycle and counts the cycles HILO_busy stays high (-1 on timeout).
  task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic rq, output int cyc);
    bit done;
    @(negedge clk);
    typeE = op; a = av; b = bv; req = rq;
    #1;
    cyc = busy ? 1 : 0;
    @(negedge clk);
    typeE = 4'd0; req = 1'b0; a = $urandom; b = $urandom;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      #1;
      if (busy) begin cyc++; @(negedge clk); end
      else done = 1'b1;
    end
    if (!done) cyc = -1;
  endtask

  task automatic readHilo(output logic [31:0] h, output logic [31:0] l);
    typeE = 4'd5; #1; h = out;
    typeE = 4'd6; #1; l = out;
    typeE = 4'd0;
  endtask

  task automatic test_reset;
    reset = 1'b0; req = 1'b0; typeE = 4'd5; a = 32'd0; b = 32'd0;
    #2;
    nCmp++;
    if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b want 0", busy); end
    nCmp++;
    if (out !== 32'd0) begin nFail++; $display("FAIL reset_hi: got %h want 0", out); end
    typeE = 4'd6; #1;
    nCmp++;
    if (out !== 32'd0) begin nFail++; $display("FAIL reset_lo: got %h want 0", out); end
    typeE = 4'd0;
    refHi = 32'd0; refLo = 32'd0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_mult;
    int cyc; logic [31:0] h, l, av, bv; logic [3:0] op; logic [63:0] exp;
    for (int i = 0; i < 7; i++) begin
      op = (i == 0) ? 4'd1 : 4'($urandom_range(1, 2));
      av = (i == 0) ? 32'hFFFFFFFF : $urandom;
      bv = (i == 0) ? 32'd2 : $urandom;
      exp = model(op, av, bv, {refHi, refLo});
      issue(op, av, bv, 1'b0, cyc);
      readHilo(h, l);
      nCmp++;
      if (cyc != 6) begin nFail++; $display("FAIL mult_busy: op %0d got %0d cycles want 6", op, cyc); end
      nCmp++;
      if ({h, l} !== exp) begin nFail++; $display("FAIL mult_result: op %0d a=%h b=%h got %h want %h", op, av, bv, {h, l}, exp); end
      {refHi, refLo} = exp;
    end
  endtask

  task automatic test_div;
    int cyc; logic [31:0] h, l, av, bv; logic [3:0] op; logic [63:0] exp;
    for (int i = 0; i < 9; i++) begin
      op = 4'($urandom_range(3, 4)); av = $urandom; bv = $urandom_range(1, 1000);
      if ($urandom_range(0, 1) == 1) bv = $urandom | 32'd1;
      if ($urandom_range(0, 1) == 1) bv = -bv;
      case (i)
        0: begin op = 4'd4; av = 32'd7;  bv = 32'd2; end
        1: begin op = 4'd3; av = -32'd7; bv = 32'd2; end
        2: begin op = 4'd3; av = 32'h80000000; bv = 32'hFFFFFFFF; end
        default: ;
      endcase
      exp = model(op, av, bv, {refHi, refLo});
      issue(op, av, bv, 1'b0, cyc);
      readHilo(h, l);
      nCmp++;
      if (cyc != 11) begin nFail++; $display("FAIL div_busy: op %0d got %0d cycles want 11", op, cyc); end
      nCmp++;
      if ({h, l} !== exp) begin nFail++; $display("FAIL div_result: op %0d a=%h b=%h got %h want %h", op, av, bv, {h, l}, exp); end
      {refHi, refLo} = exp;
    end
  endtask

  task automatic test_divzero;
    int cyc; logic [31:0] h, l;
    issue(4'd7, 32'h11, 32'd0, 1'b0, cyc);
    nCmp++;
    if (cyc != 0) begin nFail++; $display("FAIL mthi_busy: got %0d cycles want 0", cyc); end
    issue(4'd8, 32'h22, 32'd0, 1'b0, cyc);
    refHi = 32'h11; refLo = 32'h22;
    issue(4'd3, $urandom, 32'd0, 1'b0, cyc);
    readHilo(h, l);
    nCmp++;
    if (cyc != 11) begin nFail++; $display("FAIL divzero_busy: got %0d cycles want 11", cyc); end
    nCmp++;
    if ({h, l} !== {refHi, refLo}) begin nFail++; $display("FAIL divzero_hilo: got %h want %h", {h, l}, {refHi, refLo}); end
    #1;
    nCmp++;
    if (out !== 32'd0) begin nFail++; $display("FAIL out_noread: got %h want 0", out); end
  endtask

  task automatic test_flush;
    int cyc; logic [31:0] h, l, av, bv; logic [63:0] exp; bit done;
    issue(4'd1, 32'h1234, 32'h5678, 1'b1, cyc);
    readHilo(h, l);
    nCmp++;
    if (cyc != 0) begin nFail++; $display("FAIL flush_busy: got %0d cycles want 0", cyc); end
    nCmp++;
    if ({h, l} !== {refHi, refLo}) begin nFail++; $display("FAIL flush_hilo: got %h want %h", {h, l}, {refHi, refLo}); end
    av = $urandom; bv = $urandom;
    exp = model(4'd2, av, bv, {refHi, refLo});
    @(negedge clk); typeE = 4'd2; a = av; b = bv;
    @(negedge clk); typeE = 4'd0;
    @(negedge clk); typeE = 4'd1; a = $urandom; b = $urandom;
    @(negedge clk); typeE = 4'd8; a = 32'h5;
    #1;
    nCmp++;
    if (busy !== 1'b1) begin nFail++; $display("FAIL inflight_busy: got %b want 1", busy); end
    @(negedge clk); typeE = 4'd0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (busy) @(negedge clk); else done = 1'b1;
    end
    nCmp++;
    if (!done) begin nFail++; $display("FAIL inflight_timeout: busy stuck at %b want 0", busy); end
    readHilo(h, l);
    nCmp++;
    if ({h, l} !== exp) begin nFail++; $display("FAIL inflight_result: got %h want %h", {h, l}, exp); end
    {refHi, refLo} = exp;
  endtask

  task automatic test_random_mix;
    int cyc, expCyc; logic [31:0] h, l, av, bv; logic [3:0] op; logic [63:0] exp;
    logic [3:0] ops [6];
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
    for (int i = 0; i < 10; i++) begin
      op = ops[$urandom_range(0, 5)];
      av = $urandom; bv = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
      expCyc = (op <= 4'd2) ? 6 : (op <= 4'd4) ? 11 : 0;
      exp = model(op, av, bv, {refHi, refLo});
      if (op == 4'd7) exp[63:32] = av;
      if (op == 4'd8) exp[31:0] = av;
      issue(op, av, bv, 1'b0, cyc);
      readHilo(h, l);
      nCmp++;
      if (cyc != expCyc) begin nFail++; $display("FAIL mix_busy: op %0d got %0d want %0d", op, cyc, expCyc); end
      nCmp++;
      if ({h, l} !== exp) begin nFail++; $display("FAIL mix_result: op %0d a=%h b=%h got %h want %h", op, av, bv, {h, l}, exp); end
      {refHi, refLo} = exp;
    end
  endtask

  task automatic test_reset_midop;
    int cyc, cnt; logic [31:0] h, l;
    issue(4'd7, 32'h33, 32'd0, 1'b0, cyc);
    issue(4'd8, 32'h44, 32'd0, 1'b0, cyc);
    @(negedge clk); typeE = 4'd3; a = 32'd1000; b = 32'd7;
    @(negedge clk); typeE = 4'd0;
    @(negedge clk);
    @(negedge clk);
    #1; reset = 1'b0; typeE = 4'd5;
    #1;
    nCmp++;
    if (busy !== 1'b0) begin nFail++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    nCmp++;
    if (out !== 32'd0) begin nFail++; $display("FAIL rst_async_hi: got %h want 0", out); end
    typeE = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      #1; if (busy) cnt++;
      @(negedge clk);
    end
    readHilo(h, l);
    nCmp++;
    if (cnt != 0) begin nFail++; $display("FAIL rst_late_busy: got %0d busy cycles want 0", cnt); end
    nCmp++;
    if ({h, l} !== 64'd0) begin nFail++; $display("FAIL rst_no_commit: got %h want 0", {h, l}); end
    refHi = 32'd0; refLo = 32'd0;
  endtask

  task automatic test_madd;
    int cyc; logic [31:0] h, l;
    issue(4'd7, 32'd0, 32'd0, 1'b0, cyc);
    issue(4'd8, 32'd1, 32'd0, 1'b0, cyc);
    refHi = 32'd0; refLo = 32'd1;
    issue(4'd9, 32'd2, 32'd3, 1'b0, cyc);
    readHilo(h, l);
`ifdef HILO_MDU_MADD_EN
    nCmp++;
    if (cyc != 6) begin nFail++; $display("FAIL madd_busy: got %0d want 6", cyc); end
    nCmp++;
    if ({h, l} !== 64'd7) begin nFail++; $display("FAIL madd_result: got %h want 7", {h, l}); end
    refHi = 32'd0; refLo = 32'd7;
    for (int i = 0; i < 6; i++) begin
      logic [3:0] op; logic [31:0] av, bv; logic [63:0] exp;
      op = 4'($urandom_range(9, 12)); av = $urandom; bv = $urandom;
      exp = model(op, av, bv, {refHi, refLo});
      issue(op, av, bv, 1'b0, cyc);
      readHilo(h, l);
      nCmp++;
      if (cyc != 6) begin nFail++; $display("FAIL acc_busy: op %0d got %0d want 6", op, cyc); end
      nCmp++;
      if ({h, l} !== exp) begin nFail++; $display("FAIL acc_result: op %0d got %h want %h", op, {h, l}, exp); end
      {refHi, refLo} = exp;
    end
`else
    nCmp++;
    if (cyc != 0) begin nFail++; $display("FAIL madd_off_busy: got %0d want 0", cyc); end
    nCmp++;
    if ({h, l} !== 64'd1) begin nFail++; $display("FAIL madd_off_result: got %h want 1", {h, l}); end
`endif
  endtask

  initial begin
    nCmp = 0; nFail = 0;
    test_reset;
    test_mult;
    test_div;
    test_divzero;
    test_flush;
    test_random_mix;
    test_reset_midop;
    test_madd;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/hilo_mdu.md
HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port req, input, 1, exception/flush of the E-stage instruction; when high, the current op is suppressed.
REQ-004 SHALL have port HILO_typeE, input, 4, E-stage op code:
- 0 none, 1 mult, 2 multu, 3 div, 4 divu
- 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
- 9 madd, 10 maddu, 11 msub, 12 msubu
- 13-15 no-op
REQ-005 SHALL have port A, input, 32, forwarded rs operand.
REQ-006 SHALL have port B, input, 32, forwarded rt operand.
REQ-007 SHALL have port HILO_busy, output, 1, high when an op starts this cycle or one is in flight; feeds the D-stage stall unit.
REQ-008 SHALL have port HILO_out, output, 32: HI for mfhi, LO for mflo, else 0.

Function
REQ-009 A start SHALL occur when req=0, busy=0 and HILO_typeE is one of 1-4 or 9-12.
REQ-010 On a start, operands and the computed result SHALL be captured into temp registers, and the counter loaded: 5 for mult-class ops, 10 for div-class ops.
REQ-011 Internal busy SHALL be (counter != 0); HILO_busy SHALL be combinational start OR busy.
REQ-012 The counter SHALL decrement once per edge; at the edge where it moves 1->0, HI/LO SHALL load the temp result.
- Start at edge T: HILO_busy high for cycles T..T+5 (mult) or T..T+10 (div).
- New HI/LO visible from cycle T+6 (mult) or T+11 (div).
REQ-013 mult/multu SHALL produce {HI,LO} = 64-bit signed/unsigned A*B.
REQ-014 madd/maddu/msub/msubu SHALL produce {HI,LO} +/- A*B, using the HI/LO values at start, mod 2^64.
REQ-015 div SHALL be signed with truncation toward zero: LO = quotient, HI = remainder (remainder takes the sign of A).
REQ-016 A division with 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-017 Division by B=0 SHALL run the full 10 cycles and leave HI/LO unchanged.
REQ-018 mthi/mtlo SHALL write A into HI/LO at the next edge when req=0 and busy=0; otherwise the write is ignored.
REQ-019 An op code arriving while busy=1 SHALL be ignored; the in-flight op SHALL complete unaffected.
REQ-020 req=1 SHALL suppress only the E-stage op presented in that cycle and SHALL NOT abort an in-flight op.
REQ-021 HILO_out SHALL be combinational from the architectural HI/LO registers, never from temp.

Reset
REQ-022 reset=0 SHALL immediately clear HI, LO, temp and counter to 0, giving HILO_busy=0 and HILO_out=0 regardless of clk.
REQ-023 Reset during an in-flight op SHALL discard that op; no commit SHALL follow reset release.
REQ-024 Normal operation SHALL resume on the first rising edge with reset=1.

Configuration
REQ-025 Macro HILO_MDU_MADD_EN, when defined, SHALL enable op codes 9-12 as specified.
REQ-026 When HILO_MDU_MADD_EN is undefined, op codes 9-12 SHALL be no-ops: no start, HILO_busy unaffected, and no accumulate logic synthesized.

Verification
REQ-027 mult with A=0xFFFFFFFF, B=2 at cycle 0 -> HILO_busy high for cycles 0-5; from cycle 6, mfhi reads 0xFFFFFFFF and mflo reads 0xFFFFFFFE.
REQ-028 divu with A=7, B=2, then div with A=-7, B=2 -> first gives LO=3, HI=1 at cycle 11; second gives LO=0xFFFFFFFD, HI=0xFFFFFFFF; each op busy for 11 cycles.
REQ-029 div with B=0 after mthi 0x11 and mtlo 0x22 -> busy for 11 cycles, then HI=0x11 and LO=0x22.
REQ-030 mult issued with req=1, and mtlo 0x5 issued at cycle 3 of a running mult -> no start and HILO_busy=0 for the mult; the mtlo is ignored and LO equals the product.
REQ-031 reset=0 asserted at cycle 3 of a div -> HILO_busy drops without waiting for clk; HI=LO=0 after release and stays 0 with no late commit.
REQ-032 With HILO_MDU_MADD_EN defined, HI:LO=0:1 then madd A=2, B=3 -> LO=7 at cycle 6; with the macro undefined, the same stimulus gives HILO_busy=0 and LO stays 1.
